display_scan_controller: RTL



---
 rtl/display_scan_controller_if.sv | 11 +
 rtl/display_scan_controller.sv | 121 ++++++++++++
 2 files changed

// File: rtl/display_scan_controller_if.sv
// Write port of the display scan controller: the core pushes one digit value
// (hex nibble plus decimal point) per asserted cycle, with no back-pressure.
interface display_scan_controller_if;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;

  modport master (output wr_en, wr_addr, wr_data, wr_dp);
  modport slave  (input  wr_en, wr_addr, wr_data, wr_dp);
endinterface

// File: rtl/display_scan_controller.sv
// Time-multiplexed scan of NUM_DIGITS common-anode seven-segment digits through
// one shared encoder, with a blanking guard at the start of every digit slot.
module display_scan_controller #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  localparam int SEL_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  display_scan_controller_if.slave  wr,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  output logic [3:0]                num,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     anodes,
  output logic [SEL_W-1:0]          digit_sel,
  output logic                      frame_tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_DIGITS - 1);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic [SEL_W-1:0]        sel_next;
  logic                    slot_end;
  logic [3:0]              val_q [NUM_DIGITS];
  logic                    dp_q  [NUM_DIGITS];
  logic [3:0]              num_next;
  logic                    dp_next;
  logic [NUM_DIGITS-1:0]   anodes_next;
  logic                    tick_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= BLANK;
      cnt       <= '0;
      digit_sel <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      digit_sel <= sel_next;
    end
  end

  // Every output is derived from the next slot position so it lines up with
  // the registered counters without an extra cycle of latency.
  always_comb begin
    slot_end    = (cnt == CNT_LAST);
    cnt_next    = cnt + CNT_W'(1);
    sel_next    = digit_sel;
    state_next  = state;
    num_next    = '0;
    dp_next     = 1'b0;
    anodes_next = '1;

    if (slot_end) begin
      cnt_next = '0;
      sel_next = (digit_sel == SEL_LAST) ? '0 : digit_sel + SEL_W'(1);
    end

    if (cnt_next == '0)
      state_next = BLANK;
    else if (cnt_next == BLANK_END)
      state_next = DRIVE;

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_next == SEL_W'(i)) begin
        num_next = val_q[i];
        dp_next  = dp_q[i];
        if (state_next == DRIVE && digit_en[i])
          anodes_next[i] = 1'b0;
      end
    end

    // A write landing on the slot boundary for the incoming digit must be
    // shown from the very first cycle of that slot.
    if (slot_end && wr.wr_en && ({1'b0, wr.wr_addr} == 5'(sel_next))) begin
      num_next = wr.wr_data;
      dp_next  = wr.wr_dp;
    end

    tick_next = (cnt_next == '0) && (sel_next == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anodes     <= '1;
      num        <= '0;
      dp         <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      anodes     <= anodes_next;
      num        <= num_next;
      dp         <= dp_next;
      frame_tick <= tick_next;
    end
  end

  // Addresses at or beyond NUM_DIGITS match no entry and are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        val_q[i] <= '0;
        dp_q[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr.wr_en && (wr.wr_addr == 4'(i))) begin
          val_q[i] <= wr.wr_data;
          dp_q[i]  <= wr.wr_dp;
        end
      end
    end
  end

endmodule
